ring_counter_param: RTL and testbench

//   Parametrised shift-register sequence counter; successor of the fixed 4-bit ring counter.
//   - Run-time modes: one-hot ring or Johnson (twisted ring); rotate left or right.
//   - Controls: count enable and synchronous parallel load.
//   - Outputs: decoded step index, wrap pulse and illegal-state flag.
//   - Used as phase/slot sequencer and one-hot select generator in multi-channel datapaths.

---
 rtl/ring_counter_param_if.sv | 27 ++
 rtl/ring_counter_param.sv | 133 +++++++++++++
 tb/tb_ring_counter_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_counter_param_if.sv
// Control/status bundle for ring_counter_param: step controls in, sequence state and flags out.
// IDXW is derived from WIDTH and is not meant to be overridden.
interface ring_counter_param_if #(
   parameter int WIDTH = 4
);
   localparam int IDXW = $clog2(2 * WIDTH);

   logic             en;
   logic             mode;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic [IDXW-1:0]  pos;
   logic             wrap;
   logic             illegal;

   modport master (
      output en, mode, dir, load, load_val,
      input  count, pos, wrap, illegal
   );

   modport slave (
      input  en, mode, dir, load, load_val,
      output count, pos, wrap, illegal
   );
endinterface

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson sequence counter with load, step decode, wrap pulse and illegal flag.
// Optional feature: define RING_SELF_CORRECT_EN to make an enabled step out of an illegal state jump to the mode's start state.
module ring_counter_param #(
   parameter int WIDTH = 4
) (
   input logic                 clk,
   input logic                 clearn,
   ring_counter_param_if.slave bus
);
   localparam int IDXW = $clog2(2 * WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic [WIDTH-1:0] step_c;
   logic [WIDTH-1:0] wrap_tgt_c;
   logic             ring_ok_c;
   logic [IDXW-1:0]  ring_idx_c;
   logic             john_ok_c;
   logic [IDXW-1:0]  john_idx_c;
   logic             illegal_c;

   function automatic logic [WIDTH-1:0] lsb_ones(input int k);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (i < k);
      end
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] msb_ones(input int n);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (i >= WIDTH - n);
      end
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] next_state(input logic [WIDTH-1:0] c,
                                                   input logic md, input logic dr);
      logic [WIDTH-1:0] n;
      case ({md, dr})
         2'b00:   n = {c[WIDTH-2:0], c[WIDTH-1]};
         2'b01:   n = {c[0], c[WIDTH-1:1]};
         2'b10:   n = {c[WIDTH-2:0], ~c[WIDTH-1]};
         default: n = {~c[0], c[WIDTH-1:1]};
      endcase
      return n;
   endfunction

`ifdef RING_SELF_CORRECT_EN
   function automatic logic [WIDTH-1:0] start_state(input logic md);
      return md ? '0 : ONE;
   endfunction
`endif

   // State register: count and wrap are the only stored state.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         count_q <= ONE;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // Legality and step-index decode of the current register for both modes.
   always_comb begin
      ring_ok_c  = 1'b0;
      ring_idx_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (count_q == (ONE << i)) begin
            ring_ok_c  = 1'b1;
            ring_idx_c = IDXW'(i);
         end
      end
      john_ok_c  = 1'b0;
      john_idx_c = '0;
      for (int k = 0; k <= WIDTH; k++) begin
         if (count_q == lsb_ones(k)) begin
            john_ok_c  = 1'b1;
            john_idx_c = IDXW'(k);
         end
      end
      for (int n = 1; n < WIDTH; n++) begin
         if (count_q == msb_ones(n)) begin
            john_ok_c  = 1'b1;
            john_idx_c = IDXW'(2 * WIDTH - n);
         end
      end
      illegal_c = bus.mode ? ~john_ok_c : ~ring_ok_c;
   end

   // Next-state logic: load beats enable, enable beats hold.
   always_comb begin
      step_c     = next_state(count_q, bus.mode, bus.dir);
      wrap_tgt_c = bus.mode ? '0 : ONE;
      count_d    = count_q;
      wrap_d     = 1'b0;
      if (bus.load) begin
         count_d = bus.load_val;
      end else if (bus.en) begin
`ifdef RING_SELF_CORRECT_EN
         if (illegal_c) begin
            count_d = start_state(bus.mode);
         end else begin
            count_d = step_c;
            wrap_d  = (step_c == wrap_tgt_c);
         end
`else
         count_d = step_c;
         wrap_d  = (step_c == wrap_tgt_c);
`endif
      end
   end

   // Outputs: pos is forced to zero whenever the pattern is not legal for the mode.
   always_comb begin
      bus.count   = count_q;
      bus.wrap    = wrap_q;
      bus.illegal = illegal_c;
      if (illegal_c) begin
         bus.pos = '0;
      end else if (bus.mode) begin
         bus.pos = john_idx_c;
      end else begin
         bus.pos = ring_idx_c;
      end
   end
endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param at WIDTH=4 and WIDTH=5 with directed vectors.
// Stimulus queues expected outputs; a monitor compares them on the falling edge or on demand.
module tb_ring_counter_param;
   typedef struct {
      int         dut;
      logic [7:0] cnt;
      logic [7:0] pos;
      logic       wrap;
      logic       ill;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic clk = 1'b0;
   logic clearn = 1'b0;
   event mon_ev;

   always #5 clk = ~clk;

   ring_counter_param_if #(.WIDTH(4)) bus4 ();
   ring_counter_param_if #(.WIDTH(5)) bus5 ();

   ring_counter_param #(.WIDTH(4)) dut4 (.clk(clk), .clearn(clearn), .bus(bus4));
   ring_counter_param #(.WIDTH(5)) dut5 (.clk(clk), .clearn(clearn), .bus(bus5));

   task automatic check_one(input exp_t e);
      logic [7:0] ac;
      logic [7:0] ap;
      logic       aw;
      logic       ai;
      if (e.dut == 0) begin
         ac = {4'b0, bus4.count};
         ap = {5'b0, bus4.pos};
         aw = bus4.wrap;
         ai = bus4.illegal;
      end else begin
         ac = {3'b0, bus5.count};
         ap = {4'b0, bus5.pos};
         aw = bus5.wrap;
         ai = bus5.illegal;
      end
      checks++;
      if (ac !== e.cnt || ap !== e.pos || aw !== e.wrap || ai !== e.ill) begin
         errors++;
         $display("FAIL %s: got count=%b pos=%0d wrap=%b illegal=%b, want count=%b pos=%0d wrap=%b illegal=%b",
                  e.name, ac, ap, aw, ai, e.cnt, e.pos, e.wrap, e.ill);
      end
   endtask

   always begin
      @(negedge clk or mon_ev);
      while (sb.size() > 0) check_one(sb.pop_front());
   end

   task automatic push(input int d, input logic [7:0] c, input logic [7:0] p,
                       input logic w, input logic i, input string n);
      exp_t e;
      e.dut = d; e.cnt = c; e.pos = p; e.wrap = w; e.ill = i; e.name = n;
      sb.push_back(e);
   endtask

   // Entered and left 7 time units after a rising edge.
   task automatic cyc4(input logic en, input logic ld, input logic md, input logic dr,
                       input logic [3:0] lv, input logic [7:0] c, input logic [7:0] p,
                       input logic w, input logic i, input string n);
      bus4.en = en; bus4.load = ld; bus4.mode = md; bus4.dir = dr; bus4.load_val = lv;
      @(posedge clk);
      #1;
      push(0, c, p, w, i, n);
      #6;
   endtask

   task automatic cyc5(input logic en, input logic [7:0] c, input logic [7:0] p,
                       input logic w, input string n);
      bus5.en = en; bus5.load = 1'b0; bus5.mode = 1'b0; bus5.dir = 1'b0; bus5.load_val = '0;
      @(posedge clk);
      #1;
      push(1, c, p, w, 1'b0, n);
      #6;
   endtask

   task automatic peek4(input logic md, input logic [7:0] c, input logic [7:0] p,
                        input logic w, input logic i, input string n);
      bus4.en = 1'b0; bus4.load = 1'b0; bus4.mode = md;
      #1;
      push(0, c, p, w, i, n);
      ->mon_ev;
      #1;
   endtask

   task automatic rst_async(input logic [7:0] p4, input string n);
      clearn = 1'b0;
      #1;
      push(0, 8'b0000_0001, p4, 1'b0, 1'b0, n);
      push(1, 8'b0000_0001, 8'd0, 1'b0, 1'b0, {n, "_w5"});
      ->mon_ev;
      @(posedge clk);
      #7;
      clearn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus4.en = 1'b0; bus4.load = 1'b0; bus4.mode = 1'b0; bus4.dir = 1'b0; bus4.load_val = '0;
      bus5.en = 1'b0; bus5.load = 1'b0; bus5.mode = 1'b0; bus5.dir = 1'b0; bus5.load_val = '0;
      repeat (2) @(posedge clk);
      #7;
      push(0, 8'b0001, 8'd0, 1'b0, 1'b0, "reset_ring");
      ->mon_ev;
      #1;
      peek4(1'b1, 8'b0001, 8'd1, 1'b0, 1'b0, "reset_johnson_pos");
      bus4.mode = 1'b0;
      @(posedge clk);
      #7;
      clearn = 1'b1;

      // Ring, shifting left.
      cyc4(1, 0, 0, 0, 4'b0, 8'b0010, 8'd1, 0, 0, "rl1");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0100, 8'd2, 0, 0, "rl2");
      cyc4(1, 0, 0, 0, 4'b0, 8'b1000, 8'd3, 0, 0, "rl3");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0001, 8'd0, 1, 0, "rl4_wrap");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0010, 8'd1, 0, 0, "rl5");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0100, 8'd2, 0, 0, "rl6");
      cyc4(1, 0, 0, 0, 4'b0, 8'b1000, 8'd3, 0, 0, "rl7");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0001, 8'd0, 1, 0, "rl8_wrap");
      cyc4(0, 0, 0, 0, 4'b0, 8'b0001, 8'd0, 0, 0, "rl_hold");

      rst_async(8'd0, "reset_before_johnson");
      // Johnson, shifting left.
      cyc4(1, 0, 1, 0, 4'b0, 8'b0011, 8'd2, 0, 0, "jl1");
      cyc4(1, 0, 1, 0, 4'b0, 8'b0111, 8'd3, 0, 0, "jl2");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1111, 8'd4, 0, 0, "jl3");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1110, 8'd5, 0, 0, "jl4");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1100, 8'd6, 0, 0, "jl5");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1000, 8'd7, 0, 0, "jl6");
      cyc4(1, 0, 1, 0, 4'b0, 8'b0000, 8'd0, 1, 0, "jl7_wrap");
      cyc4(1, 0, 1, 0, 4'b0, 8'b0001, 8'd1, 0, 0, "jl8");
      cyc4(1, 0, 1, 0, 4'b0, 8'b0011, 8'd2, 0, 0, "jl9");
      cyc4(1, 0, 1, 0, 4'b0, 8'b0111, 8'd3, 0, 0, "jl10");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1111, 8'd4, 0, 0, "jl11");
      cyc4(1, 0, 1, 0, 4'b0, 8'b1110, 8'd5, 0, 0, "jl12");
      rst_async(8'd1, "reset_mid_johnson");

      // Ring, shifting right, with enable gaps.
      cyc4(1, 0, 0, 1, 4'b0, 8'b1000, 8'd3, 0, 0, "rr1");
      cyc4(1, 0, 0, 1, 4'b0, 8'b0100, 8'd2, 0, 0, "rr2");
      cyc4(1, 0, 0, 1, 4'b0, 8'b0010, 8'd1, 0, 0, "rr3");
      cyc4(1, 0, 0, 1, 4'b0, 8'b0001, 8'd0, 1, 0, "rr4_wrap");
      cyc4(0, 0, 0, 1, 4'b0, 8'b0001, 8'd0, 0, 0, "rr_hold1");
      cyc4(1, 0, 0, 1, 4'b0, 8'b1000, 8'd3, 0, 0, "rr5");
      cyc4(0, 0, 0, 1, 4'b0, 8'b1000, 8'd3, 0, 0, "rr_hold2");

      // Johnson, shifting right, entered from a ring state.
      cyc4(1, 0, 1, 1, 4'b0, 8'b1100, 8'd6, 0, 0, "jr1");
      cyc4(1, 0, 1, 1, 4'b0, 8'b1110, 8'd5, 0, 0, "jr2");
      cyc4(1, 0, 1, 1, 4'b0, 8'b1111, 8'd4, 0, 0, "jr3");
      cyc4(1, 0, 1, 1, 4'b0, 8'b0111, 8'd3, 0, 0, "jr4");
      cyc4(1, 0, 1, 1, 4'b0, 8'b0011, 8'd2, 0, 0, "jr5");
      cyc4(1, 0, 1, 1, 4'b0, 8'b0001, 8'd1, 0, 0, "jr6");
      cyc4(1, 0, 1, 1, 4'b0, 8'b0000, 8'd0, 1, 0, "jr7_wrap");

      // Load priority and illegal patterns.
      cyc4(1, 1, 0, 0, 4'b0100, 8'b0100, 8'd2, 0, 0, "load_over_en");
      cyc4(0, 1, 0, 0, 4'b0110, 8'b0110, 8'd0, 0, 1, "load_illegal_ring");
`ifdef RING_SELF_CORRECT_EN
      cyc4(1, 0, 0, 0, 4'b0, 8'b0001, 8'd0, 0, 0, "ring_correct");
      cyc4(1, 0, 0, 0, 4'b0, 8'b0010, 8'd1, 0, 0, "ring_after_correct");
`else
      cyc4(1, 0, 0, 0, 4'b0, 8'b1100, 8'd0, 0, 1, "ring_illegal_step1");
      cyc4(1, 0, 0, 0, 4'b0, 8'b1001, 8'd0, 0, 1, "ring_illegal_step2");
`endif
      cyc4(0, 1, 1, 0, 4'b0101, 8'b0101, 8'd0, 0, 1, "load_illegal_johnson");
`ifdef RING_SELF_CORRECT_EN
      cyc4(1, 0, 1, 0, 4'b0, 8'b0000, 8'd0, 0, 0, "johnson_correct_nowrap");
`else
      cyc4(1, 0, 1, 0, 4'b0, 8'b1011, 8'd0, 0, 1, "johnson_illegal_step");
`endif
      cyc4(0, 1, 1, 0, 4'b0011, 8'b0011, 8'd2, 0, 0, "load_johnson_0011");
      peek4(1'b0, 8'b0011, 8'd0, 1'b0, 1'b1, "mode_switch_to_ring");
      peek4(1'b1, 8'b0011, 8'd2, 1'b0, 1'b0, "mode_switch_back");
      @(posedge clk);
      #7;

      // WIDTH=5 ring run while the 4-bit counter idles.
      bus4.en = 1'b0; bus4.load = 1'b0; bus4.mode = 1'b0; bus4.dir = 1'b0;
      rst_async(8'd0, "reset_before_w5");
      cyc5(1, 8'b00010, 8'd1, 0, "w5_1");
      cyc5(1, 8'b00100, 8'd2, 0, "w5_2");
      cyc5(1, 8'b01000, 8'd3, 0, "w5_3");
      cyc5(1, 8'b10000, 8'd4, 0, "w5_4");
      cyc5(1, 8'b00001, 8'd0, 1, "w5_5_wrap");
      cyc5(1, 8'b00010, 8'd1, 0, "w5_6");
      cyc5(1, 8'b00100, 8'd2, 0, "w5_7");
      cyc5(1, 8'b01000, 8'd3, 0, "w5_8");
      cyc5(1, 8'b10000, 8'd4, 0, "w5_9");
      cyc5(1, 8'b00001, 8'd0, 1, "w5_10_wrap");
      cyc5(0, 8'b00001, 8'd0, 0, "w5_hold");

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
